// File: rtl/bconv1_pe_row_if.sv
// Bus of the first binary conv row: frame control, window input, kernel and
// threshold inputs, and bit-vector output with status.
interface bconv1_pe_row_if #(
  parameter int CH  = 8,
  parameter int TAP = 7,
  parameter int CW  = 3
);
  logic              start;
  logic              in_valid;
  logic [TAP-1:0]    in_data;
  logic              in_last;
  logic [CH*TAP-1:0] weight;
  logic [CH*CW-1:0]  thresh;
  logic              out_valid;
  logic [CH-1:0]     out_data;
  logic              out_last;
  logic              busy;
  logic [9:0]        win_cnt;

  modport master (
    output start, in_valid, in_data, in_last, weight, thresh,
    input  out_valid, out_data, out_last, busy, win_cnt
  );

  modport slave (
    input  start, in_valid, in_data, in_last, weight, thresh,
    output out_valid, out_data, out_last, busy, win_cnt
  );
endinterface

// File: rtl/bconv1_pe_row.sv
// Binary first-layer conv row: XNOR-popcount of each window against CH kernels,
// thresholded to one bit per channel. Define BCONV1_POOL_EN for stride-2 max-pool.
module bconv1_lane #(
  parameter int TAP = 7,
  parameter int CW  = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en1,
  input  logic           en2,
  input  logic [TAP-1:0] din,
  input  logic [TAP-1:0] w,
  input  logic [CW-1:0]  thr,
  output logic           b
);
  logic [TAP-1:0] x_q;
  logic [CW-1:0]  pc, pc_q;

  always_comb begin
    pc = '0;
    for (int i = 0; i < TAP; i++) pc = pc + CW'(x_q[i]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q  <= '0;
      pc_q <= '0;
    end else begin
      if (en1) x_q  <= ~(din ^ w);
      if (en2) pc_q <= pc;
    end
  end

  assign b = (pc_q >= thr);
endmodule

module bconv1_pe_row #(
  parameter int CH  = 8,
  parameter int TAP = 7,
  parameter int CW  = 3
) (
  input logic            clk,
  input logic            rst,
  bconv1_pe_row_if.slave bus
);
  localparam int STAGES = 2;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t            state;
  logic [CH*TAP-1:0] w_q;
  logic [CH*CW-1:0]  t_q;
  logic [STAGES-1:0] vld_pipe, last_pipe;
  logic              accept;
  logic [CH*TAP-1:0] w_use;
  logic [CH-1:0]     b;

  assign accept = bus.in_valid && (state == IDLE || state == RUN);
  // The first window of a frame enters S1 on the same edge the kernels are
  // latched, so it has to see the port value directly.
  assign w_use  = (state == IDLE) ? bus.weight : w_q;

  for (genvar c = 0; c < CH; c++) begin : g_lane
    bconv1_lane #(.TAP(TAP), .CW(CW)) u_lane (
      .clk (clk),
      .rst (rst),
      .en1 (accept),
      .en2 (vld_pipe[0]),
      .din (bus.in_data),
      .w   (w_use[c*TAP +: TAP]),
      .thr (t_q[c*CW +: CW]),
      .b   (b[c])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      bus.busy    <= 1'b0;
      bus.win_cnt <= '0;
      w_q         <= '0;
      t_q         <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          w_q      <= bus.weight;
          t_q      <= bus.thresh;
          bus.busy <= 1'b1;
          state    <= bus.in_last ? FLUSH : RUN;
        end
        RUN:   if (accept && bus.in_last) state <= FLUSH;
        FLUSH: if (bus.out_last) begin
          state    <= DONE;
          bus.busy <= 1'b0;
        end
        DONE:  if (bus.start) begin
          state       <= IDLE;
          bus.win_cnt <= '0;
        end
        default: state <= IDLE;
      endcase
      if (accept && bus.win_cnt != 10'h3FF) bus.win_cnt <= bus.win_cnt + 10'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe  <= '0;
      last_pipe <= '0;
    end else begin
      vld_pipe  <= {vld_pipe[0], accept};
      last_pipe <= {last_pipe[0], accept && bus.in_last};
    end
  end

`ifdef BCONV1_POOL_EN
  logic [CH-1:0] held;
  logic          have_held;

  // held stays zero while no first-of-pair is pending, so an unpaired tail
  // falls out of the same OR as a full pair.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_last  <= 1'b0;
      held          <= '0;
      have_held     <= 1'b0;
    end else begin
      bus.out_valid <= 1'b0;
      bus.out_last  <= 1'b0;
      if (state == DONE && bus.start) begin
        held      <= '0;
        have_held <= 1'b0;
      end else if (vld_pipe[1]) begin
        if (have_held || last_pipe[1]) begin
          bus.out_valid <= 1'b1;
          bus.out_data  <= held | b;
          bus.out_last  <= last_pipe[1];
          held          <= '0;
          have_held     <= 1'b0;
        end else begin
          held      <= b;
          have_held <= 1'b1;
        end
      end
    end
  end
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_last  <= 1'b0;
    end else begin
      bus.out_valid <= vld_pipe[1];
      bus.out_last  <= vld_pipe[1] && last_pipe[1];
      if (vld_pipe[1]) bus.out_data <= b;
    end
  end
`endif
endmodule

// File: doc/bconv1_pe_row.md
# bconv1_pe_row

Binary first-layer convolution row that consumes the 7-bit stride-2 ECG windows produced by the sliding-window unit. For each window it computes an XNOR-popcount against CH binary kernels and thresholds each count to one output bit per channel. When pooling is compiled in, it also applies a stride-2 binary max-pool. Outputs go to the layer-2 window buffer.

## Interface
Parameters:
- `CH`, 8: number of output channels (kernels).
- `TAP`, 7: kernel length; equals the window width.
- `CW`, 3: popcount/threshold width, equal to clog2(TAP+1).

Ports:
- `clk`, in, 1: single clock; all logic is on the rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `start`, in, 1: single-cycle pulse that re-arms the block from DONE.
- `in_valid`, in, 1: `in_data` holds a window this cycle.
- `in_data`, in, TAP: window; bit TAP-1 is the oldest sample.
- `in_last`, in, 1: marks the final window of the frame; sampled only when `in_valid` is high.
- `weight`, in, CH*TAP: kernel c occupies `weight[c*TAP +: TAP]`.
- `thresh`, in, CH*CW: threshold c occupies `thresh[c*CW +: CW]`.
- `out_valid`, out, 1: `out_data` is valid this cycle.
- `out_data`, out, CH: one output bit per channel.
- `out_last`, out, 1: high together with the final `out_valid` of the frame.
- `busy`, out, 1: high in RUN and FLUSH.
- `win_cnt`, out, 10: number of windows accepted in the current frame; saturates at 1023.

## Operation
State machine with four states: IDLE, RUN, FLUSH, DONE.
- IDLE → RUN: on `in_valid`. That window is accepted, and `weight`/`thresh` are latched into internal registers in the same edge.
- RUN: every `in_valid` cycle accepts one window. There is no backpressure, and gaps in `in_valid` are allowed.
- RUN → FLUSH: on an accepted window with `in_last` high.
- FLUSH → DONE: when the final output leaves the pipeline, i.e. in the cycle `out_last` is high.
- DONE: `in_valid` is ignored and `win_cnt` holds. `start` moves the block to IDLE and clears `win_cnt` and the pool state.
- `start` in IDLE, RUN or FLUSH is ignored.

Pipeline, per channel c:
- S1 registers `x = ~(in_data ^ w_c)`.
- S2 registers `p_c = popcount(x)`, range 0..TAP, unsigned, CW bits.
- S3 computes `b_c = (p_c >= thr_c)` as an unsigned compare. A threshold of 0 always yields 1.

Pooling (POOL_EN):
- Windows are paired in acceptance order: (0,1), (2,3), ….
- The first bit vector of a pair is held in a register. On the second, `out_data = held | b`, `out_valid` = 1.
- If a frame has an odd number of windows, the final unpaired vector is emitted as `held | 0` with `out_last`.

Other rules:
- `win_cnt` increments on each accepted window.
- The latched weights and thresholds are used for the whole frame; changes on the input ports while busy have no effect.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `out_last`=0, `busy`=0, `win_cnt`=0. State is IDLE, and all pipeline valids and pool state are cleared.
- Reset mid-operation aborts the frame immediately; no `out_last` is produced.
- Latency: a window sampled at edge E appears in S3. Without pooling, `out_valid` is high in the cycle after edge E+2 (3 edges total). With pooling, the same latency applies, measured from the second window of the pair.
- Odd-frame tail: the final unpaired vector is emitted with the same 3-edge latency from its own acceptance.
- Throughput: one window per cycle. Back-to-back windows produce back-to-back outputs without pooling, and one output every other accepted window with pooling.
- `busy` rises in the cycle after the first acceptance and falls in the cycle after `out_last`.

## Configuration
- `BCONV1_POOL_EN` defined: the stride-2 binary max-pool is built in, and `out_valid` fires once per window pair.
- `BCONV1_POOL_EN` undefined: no pool register exists. `out_valid` fires once per accepted window with `out_data = b`, and `out_last` accompanies the output of the `in_last` window.

## Test plan
- Reset check: assert `rst` mid-RUN → all outputs 0 in the same cycle, and after release the block returns to IDLE with `win_cnt`=0.
- Exact match, without pool: CH=8, all kernels 7'b1010101, thresh 4 for all channels, window 7'b1010101 → `out_data`=8'hFF exactly 3 edges after acceptance.
- Full mismatch: window 7'b0101010 with the kernels above → popcount 0 → `out_data`=8'h00. The same window with thresh 0 → `out_data`=8'hFF.
- Pooling with POOL_EN: window sequence giving b = 8'h0F then 8'hF0 → single output 8'hFF. A sequence giving 8'h00 then 8'h00 → 8'h00.
- Odd-frame tail with POOL_EN: 5 windows, the last carrying `in_last` → 3 outputs, the third with `out_last`=1, then `win_cnt`=5. `busy` drops and the block is in DONE.
- DONE and re-arm: drive `in_valid` in DONE → no output and `win_cnt` holds at 5. Pulse `start` then feed a window → `win_cnt`=1, and weights changed before that window take effect.
